psg_sn76489: RTL and testbench

- Sound generator sitting downstream of the Z80 I/O decode in the rx78 top level; the top drives `wr` on an I/O write to port FF.
- Register-compatible with the TI SN76489: three square-wave tone channels plus one noise channel, each with 4-bit attenuation.
- Produces a registered unsigned 10-bit mono sample for the audio path.

---
 rtl/psg_sn76489.sv | 227 ++++++++++++++++++++++
 tb/tb_psg_sn76489.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/psg_sn76489.sv
// SN76489-compatible sound generator: three square-wave tones plus LFSR noise, 10-bit unsigned mix.
// Optional macro PSG_CHANNEL_OUT_EN adds ch_out (per-channel amplitudes) and lfsr_dbg (live LFSR).
module psg_sn76489 #(
  parameter int PRESCALE = 16,
  parameter int LFSR_W   = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce,
  input  logic              wr,
  input  logic [7:0]        din,
`ifdef PSG_CHANNEL_OUT_EN
  output logic [31:0]       ch_out,
  output logic [LFSR_W-1:0] lfsr_dbg,
`endif
  output logic [9:0]        audio
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]     PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [LFSR_W-1:0] LFSR_SEED  = {1'b1, {(LFSR_W-1){1'b0}}};

  function automatic logic [7:0] amp_lut(input logic [3:0] att);
    case (att)
      4'd0:    amp_lut = 8'd255;
      4'd1:    amp_lut = 8'd203;
      4'd2:    amp_lut = 8'd161;
      4'd3:    amp_lut = 8'd128;
      4'd4:    amp_lut = 8'd102;
      4'd5:    amp_lut = 8'd81;
      4'd6:    amp_lut = 8'd64;
      4'd7:    amp_lut = 8'd51;
      4'd8:    amp_lut = 8'd40;
      4'd9:    amp_lut = 8'd32;
      4'd10:   amp_lut = 8'd26;
      4'd11:   amp_lut = 8'd20;
      4'd12:   amp_lut = 8'd16;
      4'd13:   amp_lut = 8'd13;
      4'd14:   amp_lut = 8'd10;
      default: amp_lut = 8'd0;
    endcase
  endfunction

  function automatic logic [6:0] noise_reload(input logic [1:0] rate);
    case (rate)
      2'b00:   noise_reload = 7'd16;
      2'b01:   noise_reload = 7'd32;
      default: noise_reload = 7'd64;
    endcase
  endfunction

  // A latch byte replaces the low nibble, a data byte replaces the upper six bits.
  function automatic logic [9:0] period_upd(input logic [9:0] old, input logic [7:0] b);
    if (b[7]) period_upd = {old[9:4], b[3:0]};
    else      period_upd = {b[5:0], old[3:0]};
  endfunction

  logic [PW-1:0]     presc_q, presc_d;
  logic              step_s;
  logic [9:0]        period_q [3];
  logic [9:0]        period_d [3];
  logic [9:0]        tcnt_q [3];
  logic [9:0]        tcnt_d [3];
  logic [2:0]        tff_q, tff_d;
  logic [3:0]        att_q [4];
  logic [3:0]        att_d [4];
  logic [2:0]        nctrl_q, nctrl_d;
  logic [6:0]        ncnt_q, ncnt_d;
  logic              nclk_q, nclk_d;
  logic              noise_shift_s;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic              lfsr_reload_s;
  logic [2:0]        latch_q, latch_d;
  logic [2:0]        reg_sel_s;
  logic [7:0]        amp_s [4];
  logic [9:0]        audio_q, audio_d;

  // Prescaler: a generator step fires on the ce that wraps the count.
  always_comb begin
    presc_d = presc_q;
    step_s  = 1'b0;
    if (ce) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = {PW{1'b0}};
        step_s  = 1'b1;
      end else begin
        presc_d = presc_q + PW'(1);
        step_s  = 1'b0;
      end
    end else begin
      presc_d = presc_q;
      step_s  = 1'b0;
    end
  end

  // CPU write decode; channel is din[6:5] (or latched), type bit selects attenuation.
  always_comb begin
    latch_d       = latch_q;
    nctrl_d       = nctrl_q;
    lfsr_reload_s = 1'b0;
    for (int i = 0; i < 3; i++) period_d[i] = period_q[i];
    for (int i = 0; i < 4; i++) att_d[i] = att_q[i];
    reg_sel_s = din[7] ? din[6:4] : latch_q;
    if (wr) begin
      if (din[7]) latch_d = din[6:4];
      else        latch_d = latch_q;
      case (reg_sel_s)
        3'b000: period_d[0] = period_upd(period_q[0], din);
        3'b010: period_d[1] = period_upd(period_q[1], din);
        3'b100: period_d[2] = period_upd(period_q[2], din);
        3'b110: begin
          nctrl_d       = din[2:0];
          lfsr_reload_s = 1'b1;
        end
        default: att_d[reg_sel_s[2:1]] = din[3:0];
      endcase
    end else begin
      latch_d       = latch_q;
      lfsr_reload_s = 1'b0;
    end
  end

  // Tone channels; periods 0/1 pin the flip-flop high for DAC-style use.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      tcnt_d[i] = tcnt_q[i];
      tff_d[i]  = tff_q[i];
      if (step_s) begin
        if (tcnt_q[i] > 10'd1) tcnt_d[i] = tcnt_q[i] - 10'd1;
        else                   tcnt_d[i] = period_q[i];
        if (period_q[i] <= 10'd1)   tff_d[i] = 1'b1;
        else if (tcnt_q[i] > 10'd1) tff_d[i] = tff_q[i];
        else                        tff_d[i] = ~tff_q[i];
      end else begin
        tcnt_d[i] = tcnt_q[i];
        tff_d[i]  = tff_q[i];
      end
    end
  end

  // Noise clock: internal divider or tone2, LFSR advances on its rising edge.
  always_comb begin
    ncnt_d        = ncnt_q;
    nclk_d        = nclk_q;
    noise_shift_s = 1'b0;
    if (step_s) begin
      if (ncnt_q > 7'd1) begin
        ncnt_d = ncnt_q - 7'd1;
        nclk_d = nclk_q;
      end else begin
        ncnt_d = noise_reload(nctrl_q[1:0]);
        nclk_d = ~nclk_q;
      end
      if (nctrl_q[1:0] == 2'b11) noise_shift_s = ~tff_q[2] & tff_d[2];
      else                       noise_shift_s = ~nclk_q & nclk_d;
    end else begin
      ncnt_d        = ncnt_q;
      nclk_d        = nclk_q;
      noise_shift_s = 1'b0;
    end
  end

  // LFSR next state; a noise-control write wins over a coincident shift.
  always_comb begin
    lfsr_d = lfsr_q;
    if (lfsr_reload_s)      lfsr_d = LFSR_SEED;
    else if (noise_shift_s) lfsr_d = {(nctrl_q[2] ? (lfsr_q[0] ^ lfsr_q[1]) : lfsr_q[0]),
                                      lfsr_q[LFSR_W-1:1]};
    else                    lfsr_d = lfsr_q;
  end

  // Per-channel amplitude and four-way mix.
  always_comb begin
    for (int i = 0; i < 3; i++) amp_s[i] = tff_q[i] ? amp_lut(att_q[i]) : 8'd0;
    amp_s[3] = lfsr_q[0] ? amp_lut(att_q[3]) : 8'd0;
    audio_d  = {2'b00, amp_s[0]} + {2'b00, amp_s[1]} + {2'b00, amp_s[2]} + {2'b00, amp_s[3]};
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q <= {PW{1'b0}};
      for (int i = 0; i < 3; i++) begin
        period_q[i] <= 10'd0;
        tcnt_q[i]   <= 10'd0;
      end
      tff_q <= 3'b111;
      for (int i = 0; i < 4; i++) att_q[i] <= 4'hF;
      nctrl_q <= 3'b000;
      ncnt_q  <= 7'd0;
      nclk_q  <= 1'b0;
      lfsr_q  <= LFSR_SEED;
      latch_q <= 3'b000;
      audio_q <= 10'd0;
    end else begin
      presc_q <= presc_d;
      for (int i = 0; i < 3; i++) begin
        period_q[i] <= period_d[i];
        tcnt_q[i]   <= tcnt_d[i];
      end
      tff_q <= tff_d;
      for (int i = 0; i < 4; i++) att_q[i] <= att_d[i];
      nctrl_q <= nctrl_d;
      ncnt_q  <= ncnt_d;
      nclk_q  <= nclk_d;
      lfsr_q  <= lfsr_d;
      latch_q <= latch_d;
      audio_q <= audio_d;
    end
  end

  assign audio = audio_q;

`ifdef PSG_CHANNEL_OUT_EN
  logic [31:0] ch_q;

  // Per-channel amplitudes, registered with the mix.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ch_q <= 32'd0;
    else       ch_q <= {amp_s[3], amp_s[2], amp_s[1], amp_s[0]};
  end

  assign ch_out   = ch_q;
  assign lfsr_dbg = lfsr_q;
`endif

endmodule

// File: tb/tb_psg_sn76489.sv
// Directed bench for psg_sn76489: vector table for tone behaviour plus hand sequences
// for ce gating, reset hold, noise (white and tone2-clocked), write/step collisions and async reset.
module tb_psg_sn76489;

  logic       clk = 1'b0;
  logic       reset;
  logic       ce;
  logic       wr;
  logic [7:0] din;
  logic [9:0] audio;

  int checks = 0;
  int errors = 0;
  int cyc;

  always #5 clk = ~clk;

  psg_sn76489 dut (
    .clk   (clk),
    .reset (reset),
    .ce    (ce),
    .wr    (wr),
    .din   (din),
    .audio (audio)
  );

  // Clock edges since reset release; with ce held high, step k lands on edge 16*k.
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  typedef struct packed {
    logic        rst;
    logic [1:0]  nw;
    logic [23:0] wbytes;
    logic [15:0] step;
    logic [9:0]  exp_audio;
    logic [79:0] name;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  function automatic logic [14:0] lfsr_next(input logic [14:0] v, input bit white);
    logic fb;
    fb = white ? (v[0] ^ v[1]) : v[0];
    return {fb, v[14:1]};
  endfunction

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: audio=%0d expected %0d (cyc %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    wr    = 1'b0;
    din   = 8'h00;
    ce    = 1'b1;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] b);
    din = b;
    wr  = 1'b1;
    tick();
    wr  = 1'b0;
    din = 8'h00;
  endtask

  task automatic goto_cyc(input int c);
    int guard;
    guard = 0;
    while (cyc < c && guard < 200000) begin
      tick();
      guard++;
    end
    if (cyc < c) begin
      errors++;
      $display("FAIL timeout: cyc=%0d expected %0d", cyc, c);
    end
  endtask

  task automatic goto_step(input int k);
    goto_cyc(16 * k + 1);
  endtask

  logic [14:0] lf;

  initial begin
    reset = 1'b1;
    ce    = 1'b1;
    wr    = 1'b0;
    din   = 8'h00;

    vecs[0]  = '{1'b1, 2'd0, 24'h000000, 16'd0,  10'd0,   "rst_k0"};
    vecs[1]  = '{1'b0, 2'd0, 24'h000000, 16'd1,  10'd0,   "rst_k1"};
    vecs[2]  = '{1'b0, 2'd0, 24'h000000, 16'd64, 10'd0,   "rst_k64"};
    vecs[3]  = '{1'b1, 2'd3, 24'h8E0090, 16'd1,  10'd0,   "tone_k1"};
    vecs[4]  = '{1'b0, 2'd0, 24'h000000, 16'd14, 10'd0,   "tone_k14"};
    vecs[5]  = '{1'b0, 2'd0, 24'h000000, 16'd15, 10'd255, "tone_k15"};
    vecs[6]  = '{1'b0, 2'd0, 24'h000000, 16'd28, 10'd255, "tone_k28"};
    vecs[7]  = '{1'b0, 2'd0, 24'h000000, 16'd29, 10'd0,   "tone_k29"};
    vecs[8]  = '{1'b0, 2'd0, 24'h000000, 16'd43, 10'd255, "tone_k43"};
    vecs[9]  = '{1'b1, 2'd3, 24'hA100B3, 16'd1,  10'd128, "p1_k1"};
    vecs[10] = '{1'b0, 2'd0, 24'h000000, 16'd2,  10'd128, "p1_k2"};
    vecs[11] = '{1'b0, 2'd0, 24'h000000, 16'd3,  10'd128, "p1_k3"};
    vecs[12] = '{1'b0, 2'd0, 24'h000000, 16'd30, 10'd128, "p1_k30"};
    vecs[13] = '{1'b1, 2'd3, 24'h820190, 16'd18, 10'd0,   "p18_k18"};
    vecs[14] = '{1'b0, 2'd0, 24'h000000, 16'd19, 10'd255, "p18_k19"};
    vecs[15] = '{1'b0, 2'd0, 24'h000000, 16'd36, 10'd255, "p18_k36"};
    vecs[16] = '{1'b0, 2'd0, 24'h000000, 16'd37, 10'd0,   "p18_k37"};

    tick();

    for (int i = 0; i < NV; i++) begin
      if (vecs[i].rst) do_reset();
      for (int j = 0; j < int'(vecs[i].nw); j++) write_byte(vecs[i].wbytes[23 - 8 * j -: 8]);
      goto_step(int'(vecs[i].step));
      check($sformatf("%0s", vecs[i].name), audio, vecs[i].exp_audio);
    end

    // Prescaler counts ce pulses, not clocks; writes are accepted with ce low.
    do_reset();
    ce = 1'b0;
    write_byte(8'h8E);
    write_byte(8'h00);
    write_byte(8'h90);
    tick();
    check("cegate_pre", audio, 10'd255);
    for (int i = 0; i < 15; i++) begin
      ce = 1'b1;
      tick();
      ce = 1'b0;
      tick();
      tick();
    end
    check("cegate_15", audio, 10'd255);
    ce = 1'b1;
    tick();
    ce = 1'b0;
    tick();
    check("cegate_16", audio, 10'd0);
    ce = 1'b1;

    // Silent after reset, no writes.
    do_reset();
    for (int k = 1; k <= 500; k++) begin
      goto_step(k);
      check("rst_hold", audio, 10'd0);
    end

    // White noise at rate 16: noise clock rises on steps 1, 33, 65, ...
    do_reset();
    write_byte(8'hE4);
    write_byte(8'hF0);
    lf = 15'h4000;
    for (int k = 1; k <= 600; k++) begin
      if ((k - 1) % 32 == 0) lf = lfsr_next(lf, 1'b1);
      goto_step(k);
      check("white", audio, lf[0] ? 10'd255 : 10'd0);
    end

    // Noise clocked by tone2 (period 8): tone2 rises on steps 9, 25, 41, ...
    do_reset();
    write_byte(8'hE7);
    write_byte(8'hC8);
    write_byte(8'h00);
    write_byte(8'hF0);
    lf = 15'h4000;
    for (int k = 1; k <= 230; k++) begin
      if (k >= 9 && (k - 9) % 16 == 0) lf = lfsr_next(lf, 1'b1);
      goto_step(k);
      check("tone2_noise", audio, lf[0] ? 10'd255 : 10'd0);
    end
    check("t2_before", audio, 10'd255);
    write_byte(8'hE7);
    tick();
    check("e7_reload", audio, 10'd0);
    lf = 15'h4000;
    for (int k = 231; k <= 270; k++) begin
      if ((k - 9) % 16 == 0) lf = lfsr_next(lf, 1'b1);
      goto_step(k);
      check("tone2_after", audio, lf[0] ? 10'd255 : 10'd0);
    end

    // Full-scale mix and write/step collision.
    do_reset();
    write_byte(8'h81);
    write_byte(8'h00);
    write_byte(8'hA1);
    write_byte(8'h00);
    write_byte(8'hC1);
    write_byte(8'h00);
    write_byte(8'h90);
    write_byte(8'hB0);
    write_byte(8'hD0);
    write_byte(8'hE4);
    write_byte(8'hF0);
    goto_step(416);
    check("mix_416", audio, 10'd765);
    goto_step(417);
    check("mix_417", audio, 10'd1020);
    write_byte(8'h80);
    goto_step(418);
    check("latch_p0", audio, 10'd1020);
    goto_cyc(16 * 419 - 1);
    write_byte(8'h3F);
    goto_step(419);
    check("coinc_step", audio, 10'd1020);
    goto_step(420);
    check("reload_3f0", audio, 10'd765);
    goto_step(421);
    check("count_3f0", audio, 10'd765);

    // Asynchronous reset clears the output without a clock edge.
    #2;
    reset = 1'b1;
    #1;
    check("async_rst", audio, 10'd0);
    tick();
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
